// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO, runtime parity and stop-bit modes, back-to-back frames.
// Define UART_TX_BREAK_EN to add line-break generation driven by break_req.
module uart_tx_param #(
  parameter int CLK_FREQ   = 16000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_start,
  input  logic [DATA_BITS-1:0]          to_tx,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          break_req,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int NW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_cnt;
  logic [NW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_en_q, two_stop_q;
  logic                 tick, hold_cnt, last_stop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt_nxt;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;

  // full is registered, so a pop in the same cycle never opens room for a push
  assign push    = tx_start && !full;
  assign head    = mem[rd_ptr];
  assign cnt_nxt = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= to_tx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      full       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= cnt_nxt;
      full       <= (cnt_nxt == CW'(FIFO_DEPTH));
    end
  end

  assign tick      = (baud_cnt == BW'(DIV - 1));
  assign last_stop = (bit_cnt == NW'(two_stop_q));

`ifdef UART_TX_BREAK_EN
  logic mark_q;
  // while the line is held low the bit timer waits; it only runs for the trailing mark
  assign hold_cnt = (state_q == S_IDLE) || (state_q == S_BREAK && !mark_q);
`else
  logic unused_break;
  assign unused_break = break_req;
  assign hold_cnt     = (state_q == S_IDLE);
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) state_d = S_BREAK;
        else
`endif
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick && bit_cnt == NW'(DATA_BITS - 1))
                  state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP: begin
        // chain straight into the next start bit when more data is queued
        if (tick && last_stop) begin
          if (fifo_count != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK:  if (mark_q && tick) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (hold_cnt) begin
        baud_cnt <= '0;
      end else if (tick) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
        if (state_q == S_DATA) shreg <= shreg >> 1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
      // frame settings are captured once per frame at pop time
      if (pop) begin
        shreg      <= head;
        par_bit    <= (^head) ^ (parity_mode == 2'b10);
        par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        two_stop_q <= two_stop;
      end
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk) begin
    if (!rst) mark_q <= 1'b0;
    else      mark_q <= (state_d == S_BREAK) && (mark_q || !break_req);
  end
`endif

  always_comb begin
    tx_out = 1'b1;
    unique case (state_q)
      S_START:  tx_out = 1'b0;
      S_DATA:   tx_out = shreg[0];
      S_PARITY: tx_out = par_bit;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  tx_out = mark_q;
`endif
      default:  tx_out = 1'b1;
    endcase
  end

  assign busy = !(state_q == S_IDLE && fifo_count == '0);

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: per-cycle check against a sample-queue line model plus literal frame checks.
// Break scenario runs only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;
  localparam int CLK_FREQ = 160000;
  localparam int BAUD     = 9600;
  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int DIV      = (CLK_FREQ + BAUD/2) / BAUD;  // 17
`ifdef UART_TX_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, tx_start, two_stop, break_req;
  logic [DW-1:0] to_tx;
  logic [1:0]    parity_mode;
  logic          tx_out, busy, full;
  logic [2:0]    fifo_count;

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .to_tx(to_tx), .parity_mode(parity_mode),
    .two_stop(two_stop), .break_req(break_req), .tx_out(tx_out), .busy(busy), .full(full),
    .fifo_count(fifo_count));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Line model: the queued bytes, and the current frame expanded into one expected level per clock.
  logic [DW-1:0] mq[$];
  bit            fr[$];
  bit            brk = 1'b0, is_mark = 1'b0, mvalid = 1'b0;
  bit            can_push, do_pop;
  logic          exp_tx, exp_busy, exp_full;
  int            exp_cnt;

  function automatic void build(input logic [DW-1:0] b, input logic [1:0] pm, input logic ts);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(b[i]);
    if (pm == 2'b01) bits.push_back(^b);
    if (pm == 2'b10) bits.push_back(~^b);
    bits.push_back(1'b1);
    if (ts) bits.push_back(1'b1);
    foreach (bits[k]) for (int j = 0; j < DIV; j++) fr.push_back(bits[k]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        mq.delete(); fr.delete();
        brk = 1'b0; is_mark = 1'b0; mvalid = 1'b1;
      end else begin
        can_push = tx_start && (mq.size() < DEPTH);
        do_pop   = 1'b0;
        if (brk) begin
          if (!break_req) begin
            brk = 1'b0; is_mark = 1'b1;
            for (int j = 0; j < DIV; j++) fr.push_back(1'b1);
          end
        end else if (fr.size() > 0) begin
          fr.delete(0);
          if (fr.size() == 0) begin
            if (is_mark) is_mark = 1'b0;
            else         do_pop  = (mq.size() > 0);
          end
        end else if (BRK_EN && break_req) begin
          brk = 1'b1;
        end else begin
          do_pop = (mq.size() > 0);
        end
        if (do_pop) build(mq.pop_front(), parity_mode, two_stop);
        if (can_push) mq.push_back(to_tx);
      end
      exp_tx   = brk ? 1'b0 : (fr.size() > 0 ? fr[0] : 1'b1);
      exp_busy = brk || (fr.size() > 0) || (mq.size() > 0);
      exp_cnt  = mq.size();
      exp_full = (exp_cnt == DEPTH);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("line_tx",    int'(tx_out),     int'(exp_tx));
        chk("line_busy",  int'(busy),       int'(exp_busy));
        chk("line_full",  int'(full),       int'(exp_full));
        chk("line_count", int'(fifo_count), exp_cnt);
      end
    end
  end

  task automatic push(input logic [DW-1:0] b);
    to_tx = b; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  // Waits for the start bit, then samples each bit at its middle.
  task automatic grab(input int nb, output logic [15:0] bits);
    int w;
    bits = '0; w = 0;
    while (tx_out !== 1'b0 && w < 1000) begin @(posedge clk); #1; w++; end
    chk("start_seen", int'(w < 1000), 1);
    repeat (DIV/2) @(posedge clk);
    #1;
    for (int k = 0; k < nb; k++) begin
      bits[k] = tx_out;
      if (k < nb - 1) begin repeat (DIV) @(posedge clk); #1; end
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (n < 5000) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 5000) begin @(negedge clk); w++; end
    chk("idle_reached", int'(w < 5000), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int n, t0, t1, w;
    rst = 1'b0; tx_start = 1'b0; to_tx = '0; parity_mode = 2'b00; two_stop = 1'b0; break_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",    int'(tx_out),     1);
    chk("rst_busy",  int'(busy),       0);
    chk("rst_full",  int'(full),       0);
    chk("rst_count", int'(fifo_count), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 8'h55, no parity, one stop
    push(8'h55);
    fork grab(10, bits); busy_len(n); join
    chk("t1_frame",    int'(bits[9:0]), 'h2AA);
    chk("t1_busy_len", n, 10*DIV + 1);
    @(posedge clk); #1;

    // 8'hAA even then odd parity; the odd frame keeps its mode despite a mid-frame change
    parity_mode = 2'b01;
    push(8'hAA);
    grab(11, bits);
    wait_idle();
    chk("t2_even_frame", int'(bits[10:0]), 'h554);
    chk("t2_even_par",   int'(bits[9]),    0);
    parity_mode = 2'b10;
    push(8'hAA);
    fork
      grab(11, bits);
      begin repeat (5) @(posedge clk); #1; parity_mode = 2'b00; end
    join
    wait_idle();
    chk("t2_odd_frame", int'(bits[10:0]), 'h754);
    chk("t2_odd_par",   int'(bits[9]),    1);

    // two stop bits
    two_stop = 1'b1;
    push(8'hF0);
    fork grab(11, bits); busy_len(n); join
    chk("t3_frame",    int'(bits[10:0]), 'h7E0);
    chk("t3_busy_len", n, 11*DIV + 1);
    two_stop = 1'b0;
    @(posedge clk); #1;

    // six pushes on consecutive clocks: one pops, four queue, the last is dropped
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      to_tx = 8'(17 * (i + 1)); tx_start = 1'b1;
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
    end
    tx_start = 1'b0;
    chk("t4_full",  int'(full),       1);
    chk("t4_count", int'(fifo_count), 4);
    w = 0;
    while (busy && w < 5000) begin @(negedge clk); w++; end
    t1 = cyc;
    chk("t4_burst_len", t1 - t0, 5*10*DIV + 1);
    @(posedge clk); #1;

    // reset in the middle of a data bit flushes the queue and idles the line
    push(8'h55);
    push(8'h33);
    repeat (50) @(posedge clk);
    #1;
    chk("t5_pre_count", int'(fifo_count), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_tx",    int'(tx_out),     1);
    chk("t5_busy",  int'(busy),       0);
    chk("t5_count", int'(fifo_count), 0);
    rst = 1'b1;
    push(8'hA5);
    grab(10, bits);
    wait_idle();
    chk("t5_clean_frame", int'(bits[9:0]), 'h34A);

`ifdef UART_TX_BREAK_EN
    // break: low while requested, then a mark of one bit plus the idle cycle before the queued start
    break_req = 1'b1;
    fork
      begin repeat (20000) @(posedge clk); #1; break_req = 1'b0; end
      begin
        repeat (100) @(posedge clk);
        #1;
        push(8'h3C);
        chk("t6_fifo_hold", int'(fifo_count), 1);
      end
      begin
        int lo, hi;
        w = 0;
        while (tx_out !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        lo = 0;
        while (tx_out === 1'b0 && lo < 30000) begin @(negedge clk); lo++; end
        hi = 0;
        while (tx_out === 1'b1 && hi < 100) begin @(negedge clk); hi++; end
        chk("t6_break_low", lo, 20000);
        chk("t6_mark_high", hi, DIV + 1);
      end
    join
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
